// File: rtl/comp_seq_if.sv
// Sample/result bundle for the comparator: the source drives the operands and
// their valid qualifier, the comparator returns its decision and counters.
interface comp_seq_if #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
);
    logic             in_valid;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [3:0]       r;
    logic             stable;
    logic [2:0]       lock_res;
    logic             change;
    logic [CNT_W-1:0] gt_cnt;
    logic [CNT_W-1:0] eq_cnt;
    logic [CNT_W-1:0] lt_cnt;

    modport master (
        output in_valid, a, b,
        input  r, stable, lock_res, change, gt_cnt, eq_cnt, lt_cnt
    );

    modport slave (
        input  in_valid, a, b,
        output r, stable, lock_res, change, gt_cnt, eq_cnt, lt_cnt
    );
endinterface

// File: rtl/comp_seq.sv
// Registered magnitude comparator with a persistence filter that only reports
// a locked GT/EQ/LT decision after PERSIST identical consecutive samples, plus
// saturating per-outcome event counters.
module comp_seq #(
    parameter int WIDTH   = 8,
    parameter int SIGNED  = 0,
    parameter int PERSIST = 3,
    parameter int CNT_W   = 8
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       clr_i,
    comp_seq_if.slave  bus
);

    localparam int SW = (PERSIST < 2) ? 1 : $clog2(PERSIST + 1);
    localparam logic [SW-1:0]    PMAX    = SW'(PERSIST);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    typedef enum logic [1:0] {IDLE, TRACK, LOCKED} state_t;

    state_t           state_q;
    logic [3:0]       r_q;
    logic [SW-1:0]    streak_q;
    logic [SW-1:0]    streak_d;
    logic [2:0]       last_res_q;
    logic             stable_q;
    logic [2:0]       lock_res_q;
    logic             change_q;
    logic [CNT_W-1:0] gt_cnt_q;
    logic [CNT_W-1:0] eq_cnt_q;
    logic [CNT_W-1:0] lt_cnt_q;

    logic [WIDTH-1:0] opA;
    logic [WIDTH-1:0] opB;
    logic             isGt;
    logic             isEq;
    logic             isLt;
    logic [2:0]       resCur;
    logic             lockNow;

    assign opA    = bus.a;
    assign opB    = bus.b;
    assign isEq   = (opA == opB);
    assign isGt   = (SIGNED != 0) ? ($signed(opA) > $signed(opB)) : (opA > opB);
    assign isLt   = !isGt && !isEq;
    assign resCur = {isGt, isEq, isLt};

    // Streak for the incoming sample: extends while the result repeats, capped
    // at PERSIST; any new result (or the first sample out of IDLE) restarts at 1
    always_comb begin
        streak_d = SW'(1);
        if (state_q != IDLE && resCur == last_res_q) begin
            streak_d = (streak_q >= PMAX) ? PMAX : streak_q + SW'(1);
        end
        lockNow = (streak_d >= PMAX);
    end

    // Filter FSM, result register and counters; all advance only on accepted samples
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            r_q        <= '0;
            streak_q   <= '0;
            last_res_q <= '0;
            stable_q   <= 1'b0;
            lock_res_q <= '0;
            change_q   <= 1'b0;
            gt_cnt_q   <= '0;
            eq_cnt_q   <= '0;
            lt_cnt_q   <= '0;
        end else if (clr_i) begin
            state_q    <= IDLE;
            r_q[3]     <= 1'b0;
            streak_q   <= '0;
            last_res_q <= '0;
            stable_q   <= 1'b0;
            lock_res_q <= '0;
            change_q   <= 1'b0;
            gt_cnt_q   <= '0;
            eq_cnt_q   <= '0;
            lt_cnt_q   <= '0;
        end else begin
            change_q <= 1'b0;
            r_q[3]   <= bus.in_valid;
            if (bus.in_valid) begin
                r_q[2:0]   <= resCur;
                last_res_q <= resCur;
                streak_q   <= streak_d;
                if (isGt && gt_cnt_q != CNT_MAX) gt_cnt_q <= gt_cnt_q + CNT_W'(1);
                if (isEq && eq_cnt_q != CNT_MAX) eq_cnt_q <= eq_cnt_q + CNT_W'(1);
                if (isLt && lt_cnt_q != CNT_MAX) lt_cnt_q <= lt_cnt_q + CNT_W'(1);
                if (lockNow) begin
                    state_q    <= LOCKED;
                    stable_q   <= 1'b1;
                    lock_res_q <= resCur;
                    change_q   <= (resCur != lock_res_q);
                end else begin
                    state_q <= TRACK;
                end
            end
        end
    end

    assign bus.r        = r_q;
    assign bus.stable   = stable_q;
    assign bus.lock_res = lock_res_q;
    assign bus.change   = change_q;
    assign bus.gt_cnt   = gt_cnt_q;
    assign bus.eq_cnt   = eq_cnt_q;
    assign bus.lt_cnt   = lt_cnt_q;

endmodule
